// File: rtl/bcd_pkg.sv
// Shared defaults and FSM state type for the binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BinWDefault      = 32;
  localparam int unsigned NumDigitsDefault = 10;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } bcd_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock,
// with registered result and leading-zero blanking mask.
module bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W      = BinWDefault,
  parameter int unsigned NUM_DIGITS = NumDigitsDefault
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   blank
);

  localparam int unsigned CntW    = $clog2(BIN_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);
  localparam logic [NUM_DIGITS-1:0] BlankRst = {{(NUM_DIGITS - 1){1'b1}}, 1'b0};

  bcd_state_e                state_q, state_d;
  logic [BIN_W-1:0]          shift_q, shift_d;
  logic [4*NUM_DIGITS-1:0]   acc_q, acc_d, acc_adj;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]   bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]     blank_q, blank_d;
  logic                      zero_run;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    blank_d  = blank_q;
    zero_run = 1'b1;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StConv;
          shift_d = bin_in;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StConv: begin
        acc_d   = {acc_adj[4*NUM_DIGITS-2:0], shift_q[BIN_W-1]};
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          bcd_d   = acc_d;
          // Scan from the top digit down; a digit is blank while all above it are zero.
          for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (acc_d[4*k +: 4] == 4'd0);
            blank_d[k] = zero_run;
          end
          blank_d[0] = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      blank_q <= BlankRst;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
    end
  end

  assign busy    = (state_q == StConv);
  assign done    = (state_q == StDone);
  assign bcd_out = bcd_q;
  assign blank   = blank_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd against an arithmetic decimal-digit model.
module tb_bin_to_bcd;

  localparam int unsigned BinW      = 32;
  localparam int unsigned NumDigits = 10;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [BinW-1:0]         bin_in = '0;
  logic                    busy;
  logic                    done;
  logic [4*NumDigits-1:0]  bcd_out;
  logic [NumDigits-1:0]    blank;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4*NumDigits-1:0] last_bcd   = '0;
  logic [NumDigits-1:0]   last_blank = 10'b1111111110;

  bin_to_bcd #(
    .BIN_W      (BinW),
    .NUM_DIGITS (NumDigits)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .blank   (blank)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal digits by repeated division.
  function automatic logic [4*NumDigits-1:0] ref_bcd(input logic [BinW-1:0] v);
    longint unsigned x = 64'(v);
    logic [4*NumDigits-1:0] r = '0;
    for (int i = 0; i < NumDigits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Digit k is blank exactly when the value has fewer than k+1 decimal digits.
  function automatic logic [NumDigits-1:0] ref_blank(input logic [BinW-1:0] v);
    longint unsigned p = 1;
    logic [NumDigits-1:0] r = '0;
    for (int k = 1; k < NumDigits; k++) begin
      p = p * 10;
      r[k] = (64'(v) < p);
    end
    return r;
  endfunction

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic convert(input logic [BinW-1:0] v, input string tag);
    int n;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = $urandom;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_hold"}, 64'(bcd_out), 64'(last_bcd));
    wait_done(64, n);
    check({tag, "_lat"}, 64'(n), 64'd32);
    check({tag, "_bcd"}, 64'(bcd_out), 64'(ref_bcd(v)));
    check({tag, "_blank"}, 64'(blank), 64'(ref_blank(v)));
    @(negedge clk);
    check({tag, "_done1"}, {62'd0, done, busy}, 64'd0);
    last_bcd   = ref_bcd(v);
    last_blank = ref_blank(v);
  endtask

  initial begin
    int n;
    int dones;
    logic [BinW-1:0] v;

    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd_out), 64'd0);
    check("rst_blank", 64'(blank), 64'h3FE);
    @(negedge clk);
    rst_n = 1'b1;

    convert(32'd123, "c123");
    check("c123_lit", 64'(bcd_out), 64'h0000000123);
    check("c123_blk", 64'(blank), 64'h3F8);
    convert(32'd0, "zero");
    convert(32'hFFFF_FFFF, "max");
    check("max_lit", 64'(bcd_out), 64'h4294967295);

    // Start pulse during CONV must be ignored
    @(negedge clk);
    start  = 1'b1;
    bin_in = 32'd987654321;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (9) begin @(negedge clk); n++; end
    start  = 1'b1;
    bin_in = 32'd5;
    @(negedge clk);
    n++;
    start = 1'b0;
    check("ign_busy", 64'(busy), 64'd1);
    check("ign_hold", 64'(bcd_out), 64'(last_bcd));
    begin
      int m;
      wait_done(64, m);
      n = n + m;
    end
    check("ign_lat", 64'(n), 64'd33);
    check("ign_bcd", 64'(bcd_out), 64'h0987654321);
    @(negedge clk);
    last_bcd = ref_bcd(32'd987654321);

    // Back-to-back with start held through DONE
    start  = 1'b1;
    bin_in = 32'd42;
    @(negedge clk);
    wait_done(64, n);
    check("b2b_lat1", 64'(n), 64'd32);
    check("b2b_bcd1", 64'(bcd_out), 64'h42);
    bin_in = 32'd7;
    @(negedge clk);
    check("b2b_nogap", {62'd0, done, busy}, 64'd1);
    start = 1'b0;
    n = 1;
    begin
      int m;
      wait_done(64, m);
      n = n + m;
    end
    check("b2b_gap", 64'(n), 64'd33);
    check("b2b_bcd2", 64'(bcd_out), 64'h7);
    check("b2b_blank2", 64'(blank), 64'h3FE);
    @(negedge clk);

    // Reset mid-conversion
    start  = 1'b1;
    bin_in = 32'd55555;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_bcd", 64'(bcd_out), 64'd0);
    check("mrst_blank", 64'(blank), 64'h3FE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("mrst_nodone", 64'(dones), 64'd0);
    check("mrst_idle", 64'(busy), 64'd0);
    last_bcd   = '0;
    last_blank = 10'b1111111110;
    convert(32'd255, "post_rst");

    // Decade boundaries and random operands
    convert(32'd9, "d9");
    convert(32'd10, "d10");
    convert(32'd999999999, "d999m");
    convert(32'd1000000000, "d1g");
    for (int i = 0; i < 20; i++) begin
      v = (i % 3 == 0) ? 32'($urandom_range(0, 99999)) : $urandom;
      convert(v, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 SHALL have parameter BIN_W, default 32, meaning width of the binary operand.
REQ-002 SHALL have parameter NUM_DIGITS, default 10, meaning number of BCD digits produced; 10 is enough to cover a 32-bit operand.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a conversion of bin_in.
REQ-006 SHALL have port bin_in, input, BIN_W bits: unsigned binary operand, sampled when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking that bcd_out is newly valid.
REQ-009 SHALL have port bcd_out, output, 4*NUM_DIGITS bits: packed BCD result; digit 0 is the least significant and sits in bits [3:0].
REQ-010 SHALL have port blank, output, NUM_DIGITS bits: bit k=1 means digit k is a leading zero and is to be shown blank; digit 0 is never blank.

Function
REQ-011 SHALL implement the FSM states IDLE, CONV and DONE.
REQ-012 SHALL accept start only in IDLE or DONE, capturing bin_in into a shift register, clearing the BCD accumulator and the iteration counter, and entering CONV on the next edge.
REQ-013 SHALL ignore start while in CONV, with no effect on the running conversion or its outputs.
REQ-014 SHALL perform one double-dabble iteration per cycle in CONV: first, each digit >= 5 gets +3 (4-bit, no carry-out); then {BCD accumulator, shift register} shifts left by 1.
REQ-015 SHALL run exactly BIN_W CONV iterations, counted by a $clog2(BIN_W+1)-bit counter, then enter DONE.
REQ-016 SHALL go from DONE to IDLE on the next edge unless start is high, in which case it goes directly to CONV (back-to-back conversions).
REQ-017 SHALL drive busy=1 exactly in CONV.
REQ-018 SHALL drive done=1 exactly in DONE, as a registered single-cycle pulse.
REQ-019 SHALL have latency such that with start sampled at edge N, busy is high for cycles N+1..N+BIN_W and done is high in cycle N+BIN_W+1.
REQ-020 SHALL update bcd_out and blank only on the CONV->DONE transition; they hold their last result through IDLE and through a subsequent CONV until the next DONE.
REQ-021 SHALL compute blank registered alongside bcd_out: bit k (k>=1) = 1 when digits k..NUM_DIGITS-1 are all zero; bit 0 = 0.
REQ-022 SHALL handle boundaries as follows: bin_in=0 gives all digits 0 and blank = all ones except bit 0; bin_in=2^BIN_W-1 gives the correct full-width result with no digit exceeding 9.

Reset
REQ-023 SHALL, with rst_n low, asynchronously force state=IDLE, busy=0, done=0, bcd_out=0, blank={NUM_DIGITS-1 ones, 0}, and clear the counter and shift registers.
REQ-024 SHALL abort any conversion in progress when reset is asserted mid-conversion, with no done pulse; after rst_n deasserts the block is in IDLE awaiting start.

Structure
REQ-025 SHALL place BIN_W and NUM_DIGITS defaults and the state enum type in shared package bcd_pkg.
REQ-026 SHALL instantiate one combinational sub-module bcd_digit_adj (4-bit in, 4-bit out, +3 if >=5) NUM_DIGITS times via generate.
REQ-027 SHALL make each bcd_out digit directly consumable by the existing per-digit seven-segment decoder; blanked digits are replaced by 4'hF by the integrator, and the decoder then shows them dark.

Verification
REQ-028 SHALL cover reset scenario: rst_n low, then start=1 with bin_in=123 -> busy rises the next cycle, done pulses 32 cycles later, bcd_out=40'h0000000123, blank=10'b1111111000.
REQ-029 SHALL cover zero operand: bin_in=0 -> bcd_out=0, blank=10'b1111111110, done is one cycle wide.
REQ-030 SHALL cover maximum operand: bin_in=32'hFFFFFFFF -> bcd_out=40'h4294967295, blank=0.
REQ-031 SHALL cover start while busy: start with 987654321, pulse start with bin_in=5 at cycle 10 -> that pulse is ignored, result=40'h0987654321.
REQ-032 SHALL cover back-to-back: start held high through DONE with bin_in changing from 42 to 7 -> second conversion starts with no IDLE gap, bcd_out=42 then 7, two done pulses 33 cycles apart.
REQ-033 SHALL cover reset mid-conversion: rst_n pulsed low at cycle 15 of a conversion -> no done pulse, bcd_out=0, busy=0, next start converts correctly.
